// File: rtl/bus_demux_writeback.sv
// Write-back bus demultiplexer: routes accepted transfers to the program counter or the register file.
// After a PC load the input is held off (inReady low) for FLUSH_CYCLES cycles.
module bus_demux_writeback #(
   parameter logic [4:0]  PC_RESET     = 5'd0,
   parameter int unsigned FLUSH_CYCLES = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] dataIn,
   input  logic        select,
   input  logic [2:0]  destReg,
   input  logic        inValid,
   output logic        inReady,
   input  logic        step,
   output logic [4:0]  pc,
   output logic        pcLoaded,
   output logic        regWrEn,
   output logic [2:0]  regWrAddr,
   output logic [4:0]  regWrData,
   output logic        truncErr
);

   localparam int unsigned CNT_W = 2;
   localparam int unsigned PC_W  = 5;

   typedef enum logic {
      ST_ACCEPT = 1'b0,
      ST_FLUSH  = 1'b1
   } state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic               accept;
   logic               pc_load;
   logic               reg_load;

   assign inReady  = (state == ST_ACCEPT) && !reset;
   assign accept   = inValid && inReady;
   assign pc_load  = accept && !select;
   assign reg_load = accept && select;

   // State and flush counter registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= ST_ACCEPT;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next-state: a PC load starts a flush; leave FLUSH the cycle after the counter hits 1
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         ST_ACCEPT: begin
            if (pc_load) begin
               state_nxt = ST_FLUSH;
               cnt_nxt   = CNT_W'(FLUSH_CYCLES);
            end
         end
         ST_FLUSH: begin
            if (cnt <= CNT_W'(1)) begin
               state_nxt = ST_ACCEPT;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         default: begin
            state_nxt = ST_ACCEPT;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Registered outputs; a load beats a same-cycle step
   always_ff @(posedge clock) begin
      if (reset) begin
         pc        <= PC_RESET;
         pcLoaded  <= 1'b0;
         regWrEn   <= 1'b0;
         regWrAddr <= '0;
         regWrData <= '0;
         truncErr  <= 1'b0;
      end else begin
         pcLoaded <= pc_load;
         regWrEn  <= reg_load;
         if (pc_load) begin
            pc <= dataIn[PC_W-1:0];
         end else if (step) begin
            pc <= pc + PC_W'(1);
         end
         if (reg_load) begin
            regWrAddr <= destReg;
            regWrData <= dataIn[PC_W-1:0];
         end
         if (accept && (dataIn[15:PC_W] != '0)) begin
            truncErr <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_bus_demux_writeback.sv
// Directed self-checking bench for bus_demux_writeback (FLUSH_CYCLES=2, PC_RESET=7).
module tb_bus_demux_writeback;

   localparam logic [4:0] PC_RST = 5'd7;

   logic        clock;
   logic        reset;
   logic [15:0] dataIn;
   logic        select;
   logic [2:0]  destReg;
   logic        inValid;
   logic        inReady;
   logic        step;
   logic [4:0]  pc;
   logic        pcLoaded;
   logic        regWrEn;
   logic [2:0]  regWrAddr;
   logic [4:0]  regWrData;
   logic        truncErr;

   int checks = 0;
   int errors = 0;

   bus_demux_writeback #(
      .PC_RESET     (PC_RST),
      .FLUSH_CYCLES (2)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .dataIn    (dataIn),
      .select    (select),
      .destReg   (destReg),
      .inValid   (inValid),
      .inReady   (inReady),
      .step      (step),
      .pc        (pc),
      .pcLoaded  (pcLoaded),
      .regWrEn   (regWrEn),
      .regWrAddr (regWrAddr),
      .regWrData (regWrData),
      .truncErr  (truncErr)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Advance one clock and settle just after the edge
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset   = 1'b1;
      dataIn  = '0;
      select  = 1'b0;
      destReg = '0;
      inValid = 1'b0;
      step    = 1'b0;

      // Reset state
      tick();
      check("rst_inready",  32'(inReady),   32'd0);
      check("rst_pc",       32'(pc),        32'(PC_RST));
      check("rst_pcloaded", 32'(pcLoaded),  32'd0);
      check("rst_wren",     32'(regWrEn),   32'd0);
      check("rst_addr",     32'(regWrAddr), 32'd0);
      check("rst_data",     32'(regWrData), 32'd0);
      check("rst_trunc",    32'(truncErr),  32'd0);
      reset = 1'b0;
      #1;
      check("idle_inready", 32'(inReady), 32'd1);

      // Register write
      inValid = 1'b1; select = 1'b1; destReg = 3'd3; dataIn = 16'h0015;
      tick();
      check("rw_wren",    32'(regWrEn),   32'd1);
      check("rw_addr",    32'(regWrAddr), 32'd3);
      check("rw_data",    32'(regWrData), 32'h15);
      check("rw_trunc",   32'(truncErr),  32'd0);
      check("rw_inready", 32'(inReady),   32'd1);
      check("rw_pc",      32'(pc),        32'(PC_RST));
      check("rw_pcld",    32'(pcLoaded),  32'd0);

      // Back-to-back write, then hold
      destReg = 3'd5; dataIn = 16'h001F;
      tick();
      check("b2b_wren", 32'(regWrEn),   32'd1);
      check("b2b_addr", 32'(regWrAddr), 32'd5);
      check("b2b_data", 32'(regWrData), 32'h1F);
      inValid = 1'b0;
      tick();
      check("hold_wren", 32'(regWrEn),   32'd0);
      check("hold_addr", 32'(regWrAddr), 32'd5);
      check("hold_data", 32'(regWrData), 32'h1F);

      // PC load, then a register write held through the flush
      inValid = 1'b1; select = 1'b0; dataIn = 16'h0009;
      tick();
      check("ld_pc",      32'(pc),       32'd9);
      check("ld_pcld",    32'(pcLoaded), 32'd1);
      check("ld_wren",    32'(regWrEn),  32'd0);
      check("fl1_ready",  32'(inReady),  32'd0);
      select = 1'b1; destReg = 3'd2; dataIn = 16'h0006;
      tick();
      check("fl2_ready",  32'(inReady),  32'd0);
      check("fl2_pcld",   32'(pcLoaded), 32'd0);
      check("fl2_wren",   32'(regWrEn),  32'd0);
      check("fl2_pc",     32'(pc),       32'd9);
      tick();
      check("flend_ready", 32'(inReady), 32'd1);
      check("flend_wren",  32'(regWrEn), 32'd0);
      tick();
      check("held_wren", 32'(regWrEn),   32'd1);
      check("held_addr", 32'(regWrAddr), 32'd2);
      check("held_data", 32'(regWrData), 32'd6);
      inValid = 1'b0;

      // Step during flush and wrap 31 -> 0 -> 1
      inValid = 1'b1; select = 1'b0; dataIn = 16'h001E;
      tick();
      check("ld30_pc", 32'(pc), 32'd30);
      inValid = 1'b0; step = 1'b1;
      tick();
      check("st_pc31",   32'(pc),      32'd31);
      check("st_ready0", 32'(inReady), 32'd0);
      tick();
      check("st_pc0",    32'(pc),      32'd0);
      check("st_ready1", 32'(inReady), 32'd1);
      tick();
      check("st_pc1",    32'(pc),      32'd1);
      step = 1'b0;

      // Load wins over a same-cycle step
      inValid = 1'b1; select = 1'b0; dataIn = 16'h0004; step = 1'b1;
      tick();
      check("ldstep_pc",   32'(pc),       32'd4);
      check("ldstep_pcld", 32'(pcLoaded), 32'd1);
      inValid = 1'b0; step = 1'b0;
      tick();
      check("ldstep_pc2",  32'(pc),       32'd4);
      check("ldstep_pcld2", 32'(pcLoaded), 32'd0);
      tick();
      check("ldstep_ready", 32'(inReady), 32'd1);

      // Truncation error is sticky
      inValid = 1'b1; select = 1'b1; destReg = 3'd1; dataIn = 16'h0120;
      tick();
      check("tr_wren",  32'(regWrEn),   32'd1);
      check("tr_data",  32'(regWrData), 32'd0);
      check("tr_err",   32'(truncErr),  32'd1);
      destReg = 3'd4; dataIn = 16'h0003;
      tick();
      check("tr_data2", 32'(regWrData), 32'd3);
      check("tr_addr2", 32'(regWrAddr), 32'd4);
      check("tr_err2",  32'(truncErr),  32'd1);
      inValid = 1'b0;
      tick();
      check("tr_err3",  32'(truncErr),  32'd1);

      // Reset in the first flush cycle
      inValid = 1'b1; select = 1'b0; dataIn = 16'h0012;
      tick();
      check("rf_pc",    32'(pc),      32'h12);
      check("rf_ready", 32'(inReady), 32'd0);
      reset = 1'b1; inValid = 1'b0;
      tick();
      check("rf_rst_pc",    32'(pc),        32'(PC_RST));
      check("rf_rst_err",   32'(truncErr),  32'd0);
      check("rf_rst_pcld",  32'(pcLoaded),  32'd0);
      check("rf_rst_wren",  32'(regWrEn),   32'd0);
      check("rf_rst_addr",  32'(regWrAddr), 32'd0);
      check("rf_rst_data",  32'(regWrData), 32'd0);
      check("rf_rst_ready", 32'(inReady),   32'd0);
      reset = 1'b0;
      #1;
      check("rf_rel_ready", 32'(inReady), 32'd1);
      tick();
      check("rf_post_ready", 32'(inReady),  32'd1);
      check("rf_post_pcld",  32'(pcLoaded), 32'd0);
      check("rf_post_wren",  32'(regWrEn),  32'd0);

      // Reset beats a same-cycle transfer and step
      reset = 1'b1; inValid = 1'b1; select = 1'b1; destReg = 3'd6; dataIn = 16'hFFFF; step = 1'b1;
      tick();
      check("rp_wren",  32'(regWrEn),  32'd0);
      check("rp_pc",    32'(pc),       32'(PC_RST));
      check("rp_err",   32'(truncErr), 32'd0);
      check("rp_addr",  32'(regWrAddr), 32'd0);
      reset = 1'b0; inValid = 1'b0; step = 1'b0;
      tick();
      check("rp_idle_wren", 32'(regWrEn), 32'd0);
      check("rp_idle_pc",   32'(pc),      32'(PC_RST));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
